// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port RAM between the CPU memory path
// (MAR/MDR) and a secondary DMA/debug requester. The CPU normally wins
// arbitration. A DMA request that keeps losing is granted once its starvation
// count reaches STARVE_LIMIT, and the CPU is stalled for that one cycle.
// Optional feature: define RAM_ARB_WPROT_EN to reject DMA writes at or above
// PROT_BASE. The write slot is still consumed, and dma_err is returned with the ack.
module ram_port_arbiter #(
    parameter int                ADDR_W       = 8,
    parameter int                DATA_W       = 16,
    parameter int                STARVE_LIMIT = 4,
    parameter logic [ADDR_W-1:0] PROT_BASE    = 'hF0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd_req,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              dma_err,
    output logic              ram_r_en,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              grant_owner
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Owner of the read issued last cycle; selects where ram_rdata is routed.
    localparam logic [1:0] RD_NONE = 2'd0;
    localparam logic [1:0] RD_CPU  = 2'd1;
    localparam logic [1:0] RD_DMA  = 2'd2;

    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic              dma_busy_q,   dma_busy_d;
    logic              dma_err_q,    dma_err_d;
    logic [1:0]        rd_owner_q,   rd_owner_d;
    logic [DATA_W-1:0] hold_q,       hold_d;

    logic cpu_req;
    logic dma_elig;
    logic starve_hit;
    logic dma_grant;
    logic cpu_grant;
    logic dma_prot;

`ifdef RAM_ARB_WPROT_EN
    assign dma_prot = dma_we & (dma_addr >= PROT_BASE);
`else
    logic unused_prot_base;
    assign unused_prot_base = ^PROT_BASE;
    assign dma_prot         = 1'b0;
`endif

    // Decide the winner of this cycle's RAM slot. Nobody is granted during reset.
    always_comb begin
        cpu_req    = cpu_rd_req | cpu_wr_req;
        dma_elig   = dma_req & ~dma_busy_q;
        starve_hit = (starve_cnt_q == STARVE_MAX);
        dma_grant  = ~reset & dma_elig & (~cpu_req | starve_hit);
        cpu_grant  = ~reset & cpu_req & ~dma_grant;
    end

    // Steer the granted requester onto the RAM port in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave one unassigned and infer a latch.
        ram_r_en    = 1'b0;
        ram_w_en    = 1'b0;
        ram_addr    = '0;
        ram_wdata   = '0;
        grant_owner = dma_grant;
        cpu_stall   = cpu_req & dma_grant;
        if (dma_grant) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_wdata;
            ram_w_en  = dma_we & ~dma_prot;
            ram_r_en  = ~dma_we;
        end else if (cpu_grant) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_w_en  = cpu_wr_req;
            ram_r_en  = cpu_rd_req & ~cpu_wr_req;  // write wins if both are asserted
        end
    end

    // Next-state logic: starvation count, DMA ack/busy, read ownership and the CPU hold register.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (dma_grant) begin
            starve_cnt_d = '0;
        end else if (dma_elig && cpu_grant && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // A DMA access issued this cycle is acked next cycle. The requester is
        // ineligible in that cycle, which caps DMA at one access per two cycles
        // and prevents the CPU from stalling on two consecutive cycles.
        dma_busy_d = dma_grant;
        dma_err_d  = dma_grant & dma_prot;

        rd_owner_d = RD_NONE;
        if (dma_grant && !dma_we) begin
            rd_owner_d = RD_DMA;
        end else if (cpu_grant && cpu_rd_req && !cpu_wr_req) begin
            rd_owner_d = RD_CPU;
        end

        hold_d = (rd_owner_q == RD_CPU) ? ram_rdata : hold_q;
    end

    // State registers with synchronous reset. Any in-flight DMA access is dropped without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
            starve_cnt_q <= '0;
            dma_busy_q   <= 1'b0;
            dma_err_q    <= 1'b0;
            rd_owner_q   <= RD_NONE;
            hold_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            dma_busy_q   <= dma_busy_d;
            dma_err_q    <= dma_err_d;
            rd_owner_q   <= rd_owner_d;
            hold_q       <= hold_d;
        end
    end

    // Return read data: pass-through in the cycle after the issue, then the CPU side keeps its held copy.
    always_comb begin
        dma_ack   = ~reset & dma_busy_q;
        dma_err   = ~reset & dma_err_q;
        dma_rdata = '0;
        cpu_rdata = '0;
        if (!reset) begin
            cpu_rdata = (rd_owner_q == RD_CPU) ? ram_rdata : hold_q;
            if (rd_owner_q == RD_DMA) begin
                dma_rdata = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized plus directed bench for ram_port_arbiter.
// A behavioural RAM drives ram_rdata. A reference model predicts every output
// each cycle. The model works from the arbitration rules: how many times the
// pending DMA request has lost, whether last cycle was a DMA slot, and a
// shadow copy of memory contents.
module tb_ram_port_arbiter;

    localparam int         LIMIT = 4;
    localparam logic [7:0] PBASE = 8'hF0;
`ifdef RAM_ARB_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd_req, cpu_wr_req;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we;
    logic [7:0]  dma_addr;
    logic [15:0] dma_wdata, dma_rdata;
    logic        dma_ack, dma_err;
    logic        ram_r_en, ram_w_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic        grant_owner;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
        .ram_r_en(ram_r_en), .ram_w_en(ram_w_en), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .grant_owner(grant_owner)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return {a, ~a} ^ 16'h5A3C;
    endfunction

    // Behavioural RAM: one-cycle read latency, and junk on the data bus when no read was issued.
    logic [15:0] ram_mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i[7:0]);
            ram_rdata <= 16'h0;
        end else begin
            if (ram_w_en) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_r_en ? ram_mem[ram_addr] : 16'($urandom);
        end
    end

    // Reference model state.
    logic [15:0] ref_mem [256];
    int          losses;
    bit          ack_pend, ack_rd, ack_err;
    logic [15:0] ack_data;
    bit          cpu_pend;
    logic [15:0] cpu_exp, cpu_hold;
    bit          m_ack;

    // DMA requester state and the DUT outputs captured on the last step.
    logic        d_req, d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata;
    logic [15:0] last_cpu_rdata, last_dma_rdata;
    logic        last_stall, last_ack, last_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        losses = 0; ack_pend = 0; ack_rd = 0; ack_err = 0; ack_data = '0;
        cpu_pend = 0; cpu_exp = '0; cpu_hold = '0; m_ack = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i[7:0]);
    endtask

    // One clock cycle: drive the inputs, check every output against the model, then advance the model.
    task automatic step(input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
        bit creq, elig, dwin, cwin, prot;
        @(posedge clk); #1;
        cpu_rd_req = rd; cpu_wr_req = wr; cpu_addr = a; cpu_wdata = d;
        dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wdata;
        @(negedge clk);
        creq = rd | wr;
        elig = d_req && !ack_pend;
        dwin = elig && (!creq || losses >= LIMIT);
        cwin = creq && !dwin;
        prot = WPROT && d_we && (d_addr >= PBASE);

        check("grant_owner", grant_owner, dwin);
        check("cpu_stall", cpu_stall, creq && dwin);
        check("ram_w_en", ram_w_en, (cwin && wr) || (dwin && d_we && !prot));
        check("ram_r_en", ram_r_en, (cwin && rd && !wr) || (dwin && !d_we));
        if (cwin) check("ram_addr_cpu", ram_addr, a);
        else if (dwin) check("ram_addr_dma", ram_addr, d_addr);
        if (cwin && wr) check("ram_wdata_cpu", ram_wdata, d);
        if (dwin && d_we && !prot) check("ram_wdata_dma", ram_wdata, d_wdata);
        check("dma_ack", dma_ack, ack_pend);
        check("dma_err", dma_err, ack_pend && ack_err);
        check("dma_rdata", dma_rdata, (ack_pend && ack_rd) ? ack_data : 16'h0);
        check("cpu_rdata", cpu_rdata, cpu_pend ? cpu_exp : cpu_hold);

        last_cpu_rdata = cpu_rdata; last_dma_rdata = dma_rdata;
        last_stall = cpu_stall; last_ack = dma_ack; last_err = dma_err;
        m_ack = ack_pend;

        if (cpu_pend) cpu_hold = cpu_exp;
        cpu_pend = cwin && rd && !wr;
        if (cpu_pend) cpu_exp = ref_mem[a];
        if (cwin && wr) ref_mem[a] = d;
        ack_pend = dwin;
        if (dwin) begin
            ack_rd  = !d_we;
            ack_err = prot;
            losses  = 0;
            if (!d_we) ack_data = ref_mem[d_addr];
            else if (!prot) ref_mem[d_addr] = d_wdata;
        end else if (elig && cwin && losses < LIMIT) begin
            losses++;
        end
    endtask

    // Hold one DMA request until its ack, with the CPU idle; returns cycles to ack.
    task automatic dma_run(input logic we, input logic [7:0] addr, input logic [15:0] wd, output int cycles);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; cycles = 0;
        do begin
            step(1'b0, 1'b0, 8'h00, 16'h0);
            cycles++;
        end while (!m_ack && cycles < 20);
        check("dma_run_ack", last_ack, 1'b1);
        d_req = 1'b0;
    endtask

    function automatic logic [7:0] rand_addr();
        return {($urandom_range(0, 3) == 0) ? 4'hF : 4'h0, 4'($urandom)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, stall_at, ack_at, waited;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

        // Reset with both requesters active: every output must stay 0.
        reset = 1'b1;
        cpu_rd_req = 1'b1; cpu_wr_req = 1'b0; cpu_addr = 8'h10; cpu_wdata = 16'h0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_r_en", ram_r_en, 1'b0);
        check("rst_ram_w_en", ram_w_en, 1'b0);
        check("rst_dma_ack", dma_ack, 1'b0);
        check("rst_cpu_stall", cpu_stall, 1'b0);
        check("rst_grant_owner", grant_owner, 1'b0);
        check("rst_ram_addr", ram_addr, 8'h0);
        check("rst_ram_wdata", ram_wdata, 16'h0);
        check("rst_cpu_rdata", cpu_rdata, 16'h0);
        check("rst_dma_rdata", dma_rdata, 16'h0);
        check("rst_dma_err", dma_err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; cpu_rd_req = 1'b0; dma_req = 1'b0;
        model_reset();

        // CPU only: store 0x1234 at 0x10, read it back, and confirm the value is held.
        step(1'b0, 1'b1, 8'h10, 16'h1234);
        step(1'b1, 1'b0, 8'h10, 16'h0);
        step(1'b0, 1'b0, 8'h00, 16'h0);
        check("t2_rdata_next", last_cpu_rdata, 16'h1234);
        step(1'b0, 1'b0, 8'h00, 16'h0);
        check("t2_rdata_held", last_cpu_rdata, 16'h1234);

        // DMA only: write 0xBEEF to 0x22, then read it back. An idle-slot grant acks on the 2nd cycle.
        dma_run(1'b1, 8'h22, 16'hBEEF, cyc);
        check("t5_latency", cyc, 2);
        dma_run(1'b0, 8'h22, 16'h0, cyc);
        check("t3_dma_rdata", last_dma_rdata, 16'hBEEF);

        // Contention: the CPU requests every cycle, so DMA is forced in on cycle 5 and acked on cycle 6.
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; d_wdata = '0;
        stall_at = -1; ack_at = -1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 8'(i), 16'h0);
            if (last_stall && stall_at < 0) stall_at = i;
            if (last_ack && ack_at < 0) begin
                ack_at = i;
                check("t4_dma_rdata", last_dma_rdata, 16'h1234);
            end
            if (m_ack) d_req = 1'b0;
        end
        check("t4_stall_cycle", stall_at, 5);
        check("t4_ack_cycle", ack_at, 6);

        // DMA writes into and just below the protected region.
        dma_run(1'b1, 8'hF5, 16'h0001, cyc);
        check("t6_err_prot", last_err, WPROT);
        dma_run(1'b0, 8'hF5, 16'h0, cyc);
        check("t6_readback_prot", last_dma_rdata, WPROT ? init_word(8'hF5) : 16'h0001);
        dma_run(1'b1, 8'hEF, 16'h5555, cyc);
        check("t6_err_below", last_err, 1'b0);
        dma_run(1'b0, 8'hEF, 16'h0, cyc);
        check("t6_readback_below", last_dma_rdata, 16'h5555);

        // Random traffic. The requester holds each DMA request until its ack and may reissue right after.
        waited = 0;
        for (int i = 0; i < 3000; i++) begin
            logic rd, wr;
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = rand_addr(); d_wdata = 16'($urandom);
                waited = 0;
            end
            step(rd, wr, rand_addr(), 16'($urandom));
            if (d_req) waited++;
            if (waited > LIMIT + 3) begin
                check("dma_wait_bound", waited, LIMIT + 3);
                waited = 0;
            end
            if (m_ack) begin
                waited = 0;
                if ($urandom_range(0, 1) == 1) begin
                    d_we = 1'($urandom); d_addr = rand_addr(); d_wdata = 16'($urandom);
                end else begin
                    d_req = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
